// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with valid/ready handshakes on both sides.
// Base RV32I operations complete in one registered cycle. Unsigned M-extension
// operations (mul, mulhu, divu, remu) iterate one bit per cycle using a shared
// 2*XLEN accumulator: shift-add for multiply, restoring division for divide.
module alu_exec_unit #(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_opcode,
  input  logic [2:0]      funct3,
  input  logic            opcode_bit5,
  input  logic            funct7_bit5,
  input  logic            funct7_bit0,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  // MUL: {partial product high, multiplier shifting out}.
  // DIV: {partial remainder, dividend shifting out / quotient shifting in}.
  logic [2*XLEN-1:0] acc_q, acc_d;
  // Multiplicand for MUL, divisor for DIV.
  logic [XLEN-1:0]   opnd_q, opnd_d;
  // Result comes from the upper accumulator half (mulhu, remu).
  logic              hi_q, hi_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q, zero_d;
  logic              illegal_q, illegal_d;

  logic              accept;
  logic              is_mop;
  logic              m_legal;
  logic              dec_illegal;
  logic [XLEN-1:0]   base_res;
  logic [CW-1:0]     shamt;
  logic signed [XLEN-1:0] sra_res;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] iter_next;
  logic [XLEN-1:0]   iter_res;
  logic              last_iter;

  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign shamt   = src_b[CW-1:0];
  assign sra_res = $signed(src_a) >>> shamt;

  // Decode the control fields and compute the single-cycle result.
  always_comb begin
    is_mop      = 1'b0;
    m_legal     = 1'b0;
    dec_illegal = 1'b0;
    base_res    = '0;
    case (alu_opcode)
      2'b00: base_res = src_a + src_b;
      2'b01: base_res = src_a - src_b;
      2'b10: begin
        if (opcode_bit5 && funct7_bit0) begin
          is_mop  = 1'b1;
          m_legal = ENABLE_M && ((funct3 == 3'b000) || (funct3 == 3'b011) ||
                                 (funct3 == 3'b101) || (funct3 == 3'b111));
          dec_illegal = !m_legal;
        end else begin
          case (funct3)
            3'b000: base_res = (opcode_bit5 && funct7_bit5) ? (src_a - src_b) : (src_a + src_b);
            3'b001: base_res = src_a << shamt;
            3'b010: base_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            3'b011: base_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            3'b100: base_res = src_a ^ src_b;
            3'b101: base_res = funct7_bit5 ? sra_res : (src_a >> shamt);
            3'b110: base_res = src_a | src_b;
            default: base_res = src_a & src_b;
          endcase
        end
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // One iteration step of the shift-add multiplier and the restoring divider.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (!div_diff[XLEN]) begin
      div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      div_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
    iter_next = (state_q == ST_MUL) ? mul_next : div_next;
    iter_res  = hi_q ? iter_next[2*XLEN-1:XLEN] : iter_next[XLEN-1:0];
    last_iter = (cnt_q == CW'(XLEN-1));
  end

  // Next-state logic: accept, iterate, and manage the output register.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    hi_d        = hi_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_mop && m_legal) begin
            state_d = funct3[2] ? ST_DIV : ST_MUL;
            cnt_d   = '0;
            opnd_d  = funct3[2] ? src_b : src_a;
            acc_d   = {{XLEN{1'b0}}, (funct3[2] ? src_a : src_b)};
            hi_d    = funct3[1];
          end else begin
            out_valid_d = 1'b1;
            result_d    = dec_illegal ? '0 : base_res;
            zero_d      = dec_illegal ? 1'b1 : (base_res == '0);
            illegal_d   = dec_illegal;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        acc_d = iter_next;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          result_d    = iter_res;
          zero_d      = (iter_res == '0);
          illegal_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      hi_q        <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      hi_q        <= hi_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and randomized checks of alu_exec_unit against an
// arithmetic reference model. A second instance built without the M extension
// shares the inputs so its illegal flagging can be observed.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_opcode;
  logic [2:0]  funct3;
  logic        opcode_bit5;
  logic        funct7_bit5;
  logic        funct7_bit0;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  logic        nom_in_ready;
  logic        nom_out_valid;
  logic [31:0] nom_result;
  logic        nom_zero;
  logic        nom_illegal;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic        nom_val_snap;
  logic        nom_ill_snap;
  logic [31:0] nom_res_snap;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(32), .ENABLE_M(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_opcode(alu_opcode), .funct3(funct3), .opcode_bit5(opcode_bit5),
    .funct7_bit5(funct7_bit5), .funct7_bit0(funct7_bit0),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  alu_exec_unit #(.XLEN(32), .ENABLE_M(1'b0)) dut_nom (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(nom_in_ready),
    .alu_opcode(alu_opcode), .funct3(funct3), .opcode_bit5(opcode_bit5),
    .funct7_bit5(funct7_bit5), .funct7_bit0(funct7_bit0),
    .src_a(src_a), .src_b(src_b), .out_valid(nom_out_valid), .out_ready(out_ready),
    .result(nom_result), .zero(nom_zero), .illegal(nom_illegal)
  );

  // Reference model: the instruction semantics in plain arithmetic.
  function automatic void model(input logic [1:0] opc, input logic [2:0] f3,
                                input logic b5, input logic f7b5, input logic f7b0,
                                input logic [31:0] a, input logic [31:0] b, input bit en_m,
                                output logic [31:0] res, output logic ill, output int lat);
    logic [63:0] prod;
    logic signed [31:0] sa;
    res  = 32'd0;
    ill  = 1'b0;
    lat  = 1;
    prod = {32'd0, a} * {32'd0, b};
    sa   = a;
    case (opc)
      2'b00: res = a + b;
      2'b01: res = a - b;
      2'b11: ill = 1'b1;
      default: begin
        if (b5 && f7b0) begin
          if (!en_m) ill = 1'b1;
          else begin
            lat = 33;
            case (f3)
              3'd0: res = prod[31:0];
              3'd3: res = prod[63:32];
              3'd5: res = (b == 0) ? 32'hFFFF_FFFF : a / b;
              3'd7: res = (b == 0) ? a : a % b;
              default: begin ill = 1'b1; lat = 1; end
            endcase
          end
        end else begin
          case (f3)
            3'd0: res = (b5 && f7b5) ? a - b : a + b;
            3'd1: res = a << b[4:0];
            3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: res = (a < b) ? 32'd1 : 32'd0;
            3'd4: res = a ^ b;
            3'd5: res = f7b5 ? 32'(sa >>> b[4:0]) : a >> b[4:0];
            3'd6: res = a | b;
            default: res = a & b;
          endcase
        end
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] opc, input logic [2:0] f3, input logic b5,
                       input logic f7b5, input logic f7b0, input logic [31:0] a,
                       input logic [31:0] b);
    in_valid    = 1'b1;
    alu_opcode  = opc;
    funct3      = f3;
    opcode_bit5 = b5;
    funct7_bit5 = f7b5;
    funct7_bit0 = f7b0;
    src_a       = a;
    src_b       = b;
  endtask

  // Issue one operation with out_ready=1, wait for its result and check it.
  task automatic run_op(input string tag, input logic [1:0] opc, input logic [2:0] f3,
                        input logic b5, input logic f7b5, input logic f7b0,
                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_res;
    logic        exp_ill;
    int          exp_lat;
    int          lat;
    logic        busy_ok;
    model(opc, f3, b5, f7b5, f7b0, a, b, 1'b1, exp_res, exp_ill, exp_lat);
    @(negedge clk);
    check({tag, " in_ready"}, in_ready, 1'b1);
    drive(opc, f3, b5, f7b5, f7b0, a, b);
    @(negedge clk);
    in_valid   = 1'b0;
    src_a      = $urandom;
    src_b      = $urandom;
    funct3     = 3'($urandom);
    alu_opcode = 2'($urandom);
    nom_val_snap = nom_out_valid;
    nom_ill_snap = nom_illegal;
    nom_res_snap = nom_result;
    lat     = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, result, exp_res);
    check({tag, " zero"}, zero, (exp_res == 32'd0));
    check({tag, " illegal"}, illegal, exp_ill);
    if (exp_lat > 1) check({tag, " in_ready low while busy"}, busy_ok, 1'b1);
    $display("op %-12s a=%08h b=%08h -> result=%08h zero=%0d illegal=%0d lat=%0d",
             tag, a, b, result, zero, illegal, lat);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] bb_exp [4];
    logic [31:0] held;
    logic [31:0] ra, rb;
    logic [1:0]  ropc;
    int          r;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_opcode = 2'b00; funct3 = 3'd0; opcode_bit5 = 1'b0;
    funct7_bit5 = 1'b0; funct7_bit0 = 1'b0; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset out_valid", out_valid, 1'b0);
    check("reset result", result, 32'd0);
    check("reset zero", zero, 1'b0);
    check("reset illegal", illegal, 1'b0);
    check("reset in_ready", in_ready, 1'b1);

    // Reset in the middle of a divide aborts it.
    @(negedge clk);
    drive(2'b10, 3'd5, 1'b1, 1'b0, 1'b1, 32'd1000, 32'd3);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("mid-div busy", in_ready, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort out_valid", out_valid, 1'b0);
    check("abort in_ready", in_ready, 1'b1);
    check("abort result", result, 32'd0);
    $display("reset during divu: out_valid=%0d in_ready=%0d result=%08h", out_valid, in_ready, result);
    run_op("add 3+4", 2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4);

    // Back-to-back base ops, one result per cycle.
    bb_exp[0] = 32'hFFFF_FFFE;
    bb_exp[1] = 32'hF800_0000;
    bb_exp[2] = 32'd1;
    bb_exp[3] = 32'd0;
    @(negedge clk);
    drive(2'b10, 3'd0, 1'b1, 1'b1, 1'b0, 32'd5, 32'd7);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      case (i)
        1: drive(2'b10, 3'd5, 1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'd4);
        2: drive(2'b10, 3'd2, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
        3: drive(2'b10, 3'd3, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
        default: in_valid = 1'b0;
      endcase
      check($sformatf("b2b[%0d] out_valid", i - 1), out_valid, 1'b1);
      check($sformatf("b2b[%0d] result", i - 1), result, bb_exp[i-1]);
      $display("b2b %0d result=%08h out_valid=%0d", i - 1, result, out_valid);
    end

    run_op("branch sub", 2'b01, 3'd0, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h1234);
    run_op("mulhu max", 2'b10, 3'd3, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mul", 2'b10, 3'd0, 1'b1, 1'b0, 1'b1, 32'd12345, 32'd678);
    check("nom mul out_valid", nom_val_snap, 1'b1);
    check("nom mul illegal", nom_ill_snap, 1'b1);
    check("nom mul result", nom_res_snap, 32'd0);
    run_op("divu 100/7", 2'b10, 3'd5, 1'b1, 1'b0, 1'b1, 32'd100, 32'd7);
    run_op("remu 100/7", 2'b10, 3'd7, 1'b1, 1'b0, 1'b1, 32'd100, 32'd7);
    run_op("divu x/0", 2'b10, 3'd5, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'd0);
    run_op("remu 9/0", 2'b10, 3'd7, 1'b1, 1'b0, 1'b1, 32'd9, 32'd0);
    run_op("m f3=010", 2'b10, 3'd2, 1'b1, 1'b0, 1'b1, 32'd5, 32'd6);
    run_op("opcode 11", 2'b11, 3'd0, 1'b0, 1'b0, 1'b0, 32'd5, 32'd6);

    // Backpressure: result must hold while out_ready is low.
    @(negedge clk);
    out_ready = 1'b0;
    drive(2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 32'd40, 32'd2);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp out_valid", out_valid, 1'b1);
    check("bp result", result, 32'd42);
    held = result;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp hold[%0d] result", i), result, 32'd42);
      check($sformatf("bp hold[%0d] in_ready", i), in_ready, 1'b0);
      check($sformatf("bp hold[%0d] out_valid", i), out_valid, 1'b1);
    end
    $display("backpressure: held result=%08h", held);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp release out_valid", out_valid, 1'b0);

    // Randomized operations against the model.
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 9);
      ropc = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r == 2) ? 2'b11 : 2'b10;
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      run_op($sformatf("rand%0d", n), ropc, 3'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), ra, rb);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised successor to the single-cycle ALU control decoder.
- Decodes {alu_opcode, funct3, opcode_bit5, funct7_bit5, funct7_bit0} internally and executes the operation on two XLEN operands.
- Base RV32I ALU ops complete in one registered cycle; optional iterative unsigned M-extension ops (mul/mulhu/divu/remu) take multiple cycles.
- Sits in the execute stage of the multi-cycle core behind a valid/ready handshake on both sides.

Parameters:
- XLEN, 32: operand/result width (≥8).
- ENABLE_M, 1: 1 = M-encodings executed; 0 = M-encodings flagged illegal.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept this cycle
- alu_opcode  in  2  00 add (lw/sw), 01 sub (branch), 10 decode funct fields, 11 illegal
- funct3  in  3  instruction funct3
- opcode_bit5  in  1  1 = R-type
- funct7_bit5  in  1  sub/sra select
- funct7_bit0  in  1  M-extension select (R-type only)
- src_a  in  XLEN  operand A
- src_b  in  XLEN  operand B (shift amount = low log2(XLEN) bits)
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts result
- result  out  XLEN  operation result
- zero  out  1  result == 0
- illegal  out  1  encoding unsupported; result forced 0

Behaviour:
- Reset: state IDLE, out_valid=0, result=0, zero=0, illegal=0, iteration counter=0. Reset mid-operation aborts; the in-flight op is discarded.
- Accept: in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready).
- Decode for alu_opcode=10 with opcode_bit5&funct7_bit0=0, by funct3:
  - 000: sub if opcode_bit5&funct7_bit5, else add
  - 001: sll
  - 010: slt (signed)
  - 011: sltu
  - 100: xor
  - 101: sra if funct7_bit5, else srl
  - 110: or
  - 111: and
- Decode for alu_opcode=10 with opcode_bit5&funct7_bit0=1 (M-ops), by funct3:
  - 000: mul (low XLEN)
  - 011: mulhu
  - 101: divu
  - 111: remu
  - Any other funct3, or ENABLE_M=0: illegal.
- Base ops and illegal: 1-cycle latency; out_valid rises the cycle after accept. Add/sub wrap modulo 2^XLEN.
- M-ops: state IDLE→MUL or DIV on accept; operands latched.
  - MUL: XLEN shift-add iterations, 2·XLEN product register.
  - DIV: XLEN restoring iterations.
  - Counter runs 0..XLEN-1; on the last iteration go to IDLE and load result. out_valid rises exactly XLEN+1 cycles after accept.
- Divide by zero: divu result = all ones, remu result = src_a; normal latency, illegal=0.
- Output register holds result/zero/illegal stable while out_valid && !out_ready.
  - out_valid clears on out_ready unless a new base op is accepted the same cycle, in which case it is reloaded (back-to-back throughput 1/cycle).
- While in MUL/DIV: in_ready=0; src/decoder input changes are ignored.
- zero is computed from the final result for every op, including illegal (zero=1).

Test Plan:
- Reset mid-divide (cycle 10 of divu) → next cycle out_valid=0, in_ready=1, result=0; a following add 3+4 returns 7.
- Base ops back-to-back with out_ready=1, XLEN=32:
  - sub 5-7 → 0xFFFFFFFE
  - sra 0x80000000>>>4 → 0xF8000000
  - slt -1<1 → 1, sltu same operands → 0
  - One result per cycle, out_valid continuous.
- alu_opcode=01, src_a=src_b=0x1234 → result 0, zero=1, latency 1.
- mulhu 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE, out_valid exactly 33 cycles after accept, in_ready=0 throughout.
- divu 100/7 → 14; remu 100/7 → 2; divu x/0 → 0xFFFFFFFF; remu 9/0 → 9.
- Backpressure: out_ready=0 for 5 cycles after an add result → result stable, in_ready=0. Funct3=010 with funct7_bit0=1 → illegal=1, result 0. ENABLE_M=0 with mul encoding → illegal=1.
